sample_capture_ram: RTL and testbench

//  Capture buffer for DUT output samples in the Costas-loop benches.

---
 rtl/sample_capture_ram.sv | 136 +++++++++++++
 tb/tb_sample_capture_ram.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_capture_ram.sv
// Capture buffer: arms, starts on a trigger, stores decimated valid samples until full,
// and exposes the contents through a registered read port.
module sample_capture_ram #(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DECIM  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              trig,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   wr_count,
  output logic              done
);

  localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIM - 1);
  localparam logic [ADDR_W:0]  WC_LAST  = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W:0]     wr_count_r;
  logic [DEC_W-1:0]    dec_cnt_r;
  logic                done_r;
  logic                done_nxt_s;
  logic                eligible_s;
  logic                wr_en_s;
  logic                rearm_s;
  logic [DATA_W-1:0]   rd_data_r;
  logic                rd_valid_r;
  logic [DATA_W-1:0]   ram_r [DEPTH];

  // Sample qualification: the trigger cycle already counts as a capture cycle.
  always_comb begin
    eligible_s = 1'b0;
    case (state_r)
      S_ARMED:   eligible_s = trig & in_valid;
      S_CAPTURE: eligible_s = in_valid;
      default:   eligible_s = 1'b0;
    endcase
    wr_en_s = eligible_s && (dec_cnt_r == DEC_W'(0)) && !wr_count_r[ADDR_W];
    rearm_s = ((state_r == S_IDLE) || (state_r == S_DONE)) && arm;
  end

  // Next-state logic; CAPTURE ends only on the write that fills the buffer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE:    state_nxt_s = arm  ? S_ARMED   : S_IDLE;
      S_ARMED:   state_nxt_s = trig ? S_CAPTURE : S_ARMED;
      S_CAPTURE: begin
        if (wr_en_s && (wr_count_r == WC_LAST)) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_CAPTURE;
        end
      end
      S_DONE:    state_nxt_s = arm  ? S_ARMED   : S_DONE;
      default:   state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode, registered alongside the state.
  always_comb begin
    done_nxt_s = (state_nxt_s == S_DONE);
  end

  // State and done registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Write counter and decimation phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_count_r <= '0;
      dec_cnt_r  <= '0;
    end else if (rearm_s) begin
      wr_count_r <= '0;
      dec_cnt_r  <= '0;
    end else if (eligible_s) begin
      dec_cnt_r <= (dec_cnt_r == DEC_LAST) ? DEC_W'(0) : dec_cnt_r + DEC_W'(1);
      if (wr_en_s) begin
        wr_count_r <= wr_count_r + (ADDR_W + 1)'(1);
      end
    end
  end

  // Sample storage; deliberately not reset so data survives a mid-capture reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      ram_r[wr_count_r[ADDR_W-1:0]] <= in_data;
    end
  end

  // Registered read port; reading ram_r before the NBA write gives old data on collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= ram_r[rd_addr];
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign state    = state_r;
  assign wr_count = wr_count_r;
  assign done     = done_r;

endmodule

// File: tb/tb_sample_capture_ram.sv
// Bench for sample_capture_ram: one DECIM=1 and one DECIM=4 instance, DEPTH=16, DATA_W=8.
module tb_sample_capture_ram;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       arm_a = 1'b0, trig_a = 1'b0, vld_a = 1'b0, rd_en_a = 1'b0;
  logic [7:0] din_a = 8'd0, rd_data_a;
  logic [3:0] rd_addr_a = 4'd0;
  logic       rd_valid_a, done_a;
  logic [1:0] state_a;
  logic [4:0] wc_a;
  logic       arm_b = 1'b0, trig_b = 1'b0, vld_b = 1'b0, rd_en_b = 1'b0;
  logic [7:0] din_b = 8'd0, rd_data_b;
  logic [3:0] rd_addr_b = 4'd0;
  logic       rd_valid_b, done_b;
  logic [1:0] state_b;
  logic [4:0] wc_b;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] model_a [16];
  logic [7:0] model_b [16];
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  logic issued_a = 1'b0, issued_b = 1'b0;

  always #5 clk = ~clk;

  sample_capture_ram #(.DATA_W(8), .DEPTH(16), .DECIM(1)) u_dut_a (
    .clk(clk), .rst(rst), .arm(arm_a), .trig(trig_a), .in_valid(vld_a), .in_data(din_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .state(state_a), .wr_count(wc_a), .done(done_a));

  sample_capture_ram #(.DATA_W(8), .DEPTH(16), .DECIM(4)) u_dut_b (
    .clk(clk), .rst(rst), .arm(arm_b), .trig(trig_b), .in_valid(vld_b), .in_data(din_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .state(state_b), .wr_count(wc_b), .done(done_b));

  // Remember which cycles issued a read so rd_valid latency can be checked.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_a <= 1'b0;
      issued_b <= 1'b0;
    end else begin
      issued_a <= rd_en_a;
      issued_b <= rd_en_b;
    end
  end

  // Read scoreboard: pop the expected word whenever the DUT presents rd_valid.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst) begin
      n_cmp++;
      if (rd_valid_a !== issued_a) begin
        n_err++; $display("FAIL rd_valid_a: got %b want %b", rd_valid_a, issued_a);
      end
      if (rd_valid_a === 1'b1) begin
        n_cmp++;
        if (exp_a.size() == 0) begin
          n_err++; $display("FAIL rd_data_a: unexpected read data %h", rd_data_a);
        end else begin
          e = exp_a.pop_front();
          if (rd_data_a !== e) begin
            n_err++; $display("FAIL rd_data_a: got %h want %h", rd_data_a, e);
          end
        end
      end
      n_cmp++;
      if (rd_valid_b !== issued_b) begin
        n_err++; $display("FAIL rd_valid_b: got %b want %b", rd_valid_b, issued_b);
      end
      if (rd_valid_b === 1'b1) begin
        n_cmp++;
        if (exp_b.size() == 0) begin
          n_err++; $display("FAIL rd_data_b: unexpected read data %h", rd_data_b);
        end else begin
          e = exp_b.pop_front();
          if (rd_data_b !== e) begin
            n_err++; $display("FAIL rd_data_b: got %h want %h", rd_data_b, e);
          end
        end
      end
    end
  end

  task automatic drive(input bit sel, input logic a, input logic t, input logic v,
                       input logic [7:0] d);
    @(negedge clk);
    if (sel) begin
      arm_b = a; trig_b = t; vld_b = v; din_b = d;
    end else begin
      arm_a = a; trig_a = t; vld_a = v; din_a = d;
    end
  endtask

  task automatic read_range(input bit sel, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (sel) begin
        rd_en_b = 1'b1; rd_addr_b = 4'(i); exp_b.push_back(model_b[i]);
      end else begin
        rd_en_a = 1'b1; rd_addr_a = 4'(i); exp_a.push_back(model_a[i]);
      end
    end
    @(negedge clk);
    rd_en_a = 1'b0; rd_en_b = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (state_a !== 2'd0) begin n_err++; $display("FAIL reset_state_a: got %0d want 0", state_a); end
    n_cmp++; if (wc_a !== 5'd0) begin n_err++; $display("FAIL reset_wc_a: got %0d want 0", wc_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done_a: got %b want 0", done_a); end
    n_cmp++; if (rd_valid_a !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid_a: got %b want 0", rd_valid_a); end
    n_cmp++; if (rd_data_a !== 8'd0) begin n_err++; $display("FAIL reset_rd_data_a: got %h want 00", rd_data_a); end
    n_cmp++; if (state_b !== 2'd0) begin n_err++; $display("FAIL reset_state_b: got %0d want 0", state_b); end
    n_cmp++; if (wc_b !== 5'd0) begin n_err++; $display("FAIL reset_wc_b: got %0d want 0", wc_b); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] pat = 16'b1011_0010_1110_0101;
    drive(0, 1'b1, 1'b0, 1'b0, 8'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_cmp++; if (state_a !== 2'd1) begin n_err++; $display("FAIL basic_armed: got %0d want 1", state_a); end
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b0, (i == 0), 1'b1, {7'd0, pat[15-i]});
      model_a[i] = {7'd0, pat[15-i]};
      if (i > 0) begin
        n_cmp++; if (wc_a !== 5'(i)) begin n_err++; $display("FAIL basic_wc: got %0d want %0d", wc_a, i); end
        n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL basic_early_done: got %b want 0", done_a); end
      end
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_cmp++; if (wc_a !== 5'd16) begin n_err++; $display("FAIL basic_full_wc: got %0d want 16", wc_a); end
    n_cmp++; if (done_a !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b want 1", done_a); end
    n_cmp++; if (state_a !== 2'd3) begin n_err++; $display("FAIL basic_state_done: got %0d want 3", state_a); end
    read_range(0, 16);
    n_cmp++; if (rd_data_a !== model_a[15]) begin n_err++; $display("FAIL basic_rd_hold: got %h want %h", rd_data_a, model_a[15]); end
  endtask

  task automatic test_ignore_full();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1'b0, 1'b1, 1'b1, 8'hFF);
      n_cmp++; if (wc_a !== 5'd16) begin n_err++; $display("FAIL full_wc: got %0d want 16", wc_a); end
      n_cmp++; if (state_a !== 2'd3) begin n_err++; $display("FAIL full_state: got %0d want 3", state_a); end
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
    read_range(0, 16);
  endtask

  task automatic test_gaps();
    drive(0, 1'b1, 1'b0, 1'b0, 8'd0);
    drive(0, 1'b0, 1'b0, 1'b1, 8'h77);
    drive(0, 1'b0, 1'b1, 1'b0, 8'hAA);
    n_cmp++; if (wc_a !== 5'd0 || state_a !== 2'd1) begin n_err++; $display("FAIL gaps_no_trig_write: got st=%0d wc=%0d want st=1 wc=0", state_a, wc_a); end
    drive(0, 1'b0, 1'b0, 1'b0, 8'hEE);
    n_cmp++; if (wc_a !== 5'd0 || state_a !== 2'd2) begin n_err++; $display("FAIL gaps_trig_novalid: got st=%0d wc=%0d want st=2 wc=0", state_a, wc_a); end
    for (int i = 0; i < 16; i++) begin
      drive(0, 1'b0, 1'b0, 1'b1, 8'h10 + 8'(i));
      model_a[i] = 8'h10 + 8'(i);
      drive(0, 1'b0, 1'b0, 1'b0, 8'hEE);
      n_cmp++; if (wc_a !== 5'(i + 1)) begin n_err++; $display("FAIL gaps_wc: got %0d want %0d", wc_a, i + 1); end
    end
    n_cmp++; if (state_a !== 2'd3) begin n_err++; $display("FAIL gaps_done: got %0d want 3", state_a); end
    read_range(0, 16);
  endtask

  task automatic test_rearm_collision();
    logic [7:0] old0 = model_a[0];
    logic [7:0] newv = ~model_a[0];
    drive(0, 1'b1, 1'b0, 1'b0, 8'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_cmp++; if (state_a !== 2'd1 || wc_a !== 5'd0) begin n_err++; $display("FAIL rearm: got st=%0d wc=%0d want st=1 wc=0", state_a, wc_a); end
    drive(0, 1'b0, 1'b1, 1'b1, newv);
    rd_en_a = 1'b1; rd_addr_a = 4'd0; exp_a.push_back(old0);
    drive(0, 1'b1, 1'b1, 1'b1, 8'h5A);
    exp_a.push_back(newv);
    model_a[0] = newv; model_a[1] = 8'h5A;
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
    rd_en_a = 1'b0;
    n_cmp++; if (state_a !== 2'd2 || wc_a !== 5'd2) begin n_err++; $display("FAIL no_restart: got st=%0d wc=%0d want st=2 wc=2", state_a, wc_a); end
    for (int i = 2; i < 16; i++) begin
      drive(0, 1'b0, 1'b0, 1'b1, 8'h20 + 8'(i));
      model_a[i] = 8'h20 + 8'(i);
    end
    drive(0, 1'b0, 1'b0, 1'b0, 8'd0);
    n_cmp++; if (done_a !== 1'b1 || wc_a !== 5'd16) begin n_err++; $display("FAIL rearm_fill: got done=%b wc=%0d want done=1 wc=16", done_a, wc_a); end
    read_range(0, 16);
  endtask

  task automatic test_decim();
    drive(1, 1'b1, 1'b0, 1'b0, 8'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 40; i++) begin
      drive(1, 1'b0, (i == 0), 1'b1, 8'(i));
      if (i % 4 == 0) model_b[i/4] = 8'(i);
    end
    drive(1, 1'b0, 1'b0, 1'b0, 8'd0);
    n_cmp++; if (wc_b !== 5'd10) begin n_err++; $display("FAIL decim_wc: got %0d want 10", wc_b); end
    n_cmp++; if (state_b !== 2'd2 || done_b !== 1'b0) begin n_err++; $display("FAIL decim_state: got st=%0d done=%b want st=2 done=0", state_b, done_b); end
    read_range(1, 10);
  endtask

  task automatic test_reset_mid_capture();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (state_b !== 2'd0 || wc_b !== 5'd0 || done_b !== 1'b0) begin n_err++; $display("FAIL midrst_b: got st=%0d wc=%0d done=%b want 0/0/0", state_b, wc_b, done_b); end
    n_cmp++; if (rd_data_b !== 8'd0) begin n_err++; $display("FAIL midrst_rd_data: got %h want 00", rd_data_b); end
    n_cmp++; if (state_a !== 2'd0 || done_a !== 1'b0) begin n_err++; $display("FAIL midrst_a: got st=%0d done=%b want 0/0", state_a, done_a); end
    rst = 1'b0;
    read_range(1, 10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_full();
    test_gaps();
    test_rearm_collision();
    test_decim();
    test_reset_mid_capture();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", exp_a.size(), exp_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
